big_data_2d_sweep_ctrl: RTL and testbench

BIG_DATA_2D_SWEEP_CTRL -- requirements
Module: big_data_2d_sweep_ctrl

---
 rtl/big_data_2d_sweep_ctrl.sv | 177 +++++++++++++++++
 tb/tb_big_data_2d_sweep_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/big_data_2d_sweep_ctrl.sv
// Periodic 2-D sweep controller: waits PERIOD cycles, streams every element of two
// memories to a consumer in x/y order, writes results back, and repeats REPEAT times.
module big_data_2d_sweep_ctrl #(
  parameter int SIZE_X = 100,
  parameter int SIZE_Y = 10,
  parameter int PERIOD = 1000,
  parameter int REPEAT = 100000,
  parameter int DW = 32,
  localparam int N  = SIZE_X * SIZE_Y,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int XW = (SIZE_X > 1) ? $clog2(SIZE_X) : 1,
  localparam int YW = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data_i,
  input  logic [DW-1:0] rd_data_io,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [DW-1:0] out_i,
  output logic [DW-1:0] out_io,
  input  logic          wb_valid,
  input  logic [DW-1:0] wb_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic [31:0]   pass_count
);

  localparam int IW = AW + 1;
  localparam logic [IW-1:0] N_IDX = IW'(N);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     cnt_reg;
  logic [IW-1:0]   iss_idx_reg, wb_idx_reg;
  logic [XW-1:0]   iss_x_reg, pend_x_reg, skid_x_reg;
  logic [YW-1:0]   iss_y_reg, pend_y_reg, skid_y_reg;
  logic            pend_reg, skid_valid_reg;
  logic [DW-1:0]   skid_i_reg, skid_io_reg;

  logic iss_more, wb_more, pipe_empty, sweep_done, last_pass, run_start, out_free;

  assign iss_more   = (iss_idx_reg != N_IDX);
  assign wb_more    = (wb_idx_reg != N_IDX);
  assign pipe_empty = !out_valid && !pend_reg && !skid_valid_reg;
  assign sweep_done = (state_reg == S_DRAIN) && !wb_more;
  assign last_pass  = (pass_count + 32'd1) == 32'(REPEAT);
  assign run_start  = start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign out_free   = !out_valid || out_ready;

  // A read lands one cycle later; the skid slot catches it if the consumer stalls meanwhile.
  assign rd_en   = !rst && !abort && (state_reg == S_SWEEP) && iss_more && !skid_valid_reg && out_free;
  assign rd_addr = iss_idx_reg[AW-1:0];
  assign wr_en   = !rst && !abort && (state_reg == S_SWEEP || state_reg == S_DRAIN) && wb_valid && wb_more;
  assign wr_addr = wb_idx_reg[AW-1:0];
  assign wr_data = wr_en ? wb_data : '0;
  assign busy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done    = (state_reg == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_WAIT;
      S_WAIT:  if (cnt_reg == '0) state_next = S_SWEEP;
      S_SWEEP: if (!iss_more && pipe_empty) state_next = S_DRAIN;
      S_DRAIN: if (sweep_done) state_next = last_pass ? S_DONE : S_WAIT;
      S_DONE:  if (start) state_next = S_WAIT;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      pass_count     <= '0;
      iss_idx_reg    <= '0;
      wb_idx_reg     <= '0;
      iss_x_reg      <= '0;
      iss_y_reg      <= '0;
      pend_reg       <= 1'b0;
      pend_x_reg     <= '0;
      pend_y_reg     <= '0;
      skid_valid_reg <= 1'b0;
      skid_x_reg     <= '0;
      skid_y_reg     <= '0;
      skid_i_reg     <= '0;
      skid_io_reg    <= '0;
      out_valid      <= 1'b0;
      out_x          <= '0;
      out_y          <= '0;
      out_i          <= '0;
      out_io         <= '0;
    end else if (abort) begin
      cnt_reg        <= '0;
      iss_idx_reg    <= '0;
      wb_idx_reg     <= '0;
      iss_x_reg      <= '0;
      iss_y_reg      <= '0;
      pend_reg       <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      if (state_next == S_WAIT && state_reg != S_WAIT)
        cnt_reg <= 32'(PERIOD - 1);
      else if (state_reg == S_WAIT && cnt_reg != '0)
        cnt_reg <= cnt_reg - 32'd1;

      if (run_start)       pass_count <= '0;
      else if (sweep_done) pass_count <= pass_count + 32'd1;

      // x/y follow the linear index as a pair of counters, Y fastest.
      if (rd_en) begin
        iss_idx_reg <= iss_idx_reg + IW'(1);
        if (iss_y_reg == YW'(SIZE_Y - 1)) begin
          iss_y_reg <= '0;
          iss_x_reg <= iss_x_reg + XW'(1);
        end else begin
          iss_y_reg <= iss_y_reg + YW'(1);
        end
        pend_x_reg <= iss_x_reg;
        pend_y_reg <= iss_y_reg;
      end
      pend_reg <= rd_en;

      if (wr_en) wb_idx_reg <= wb_idx_reg + IW'(1);

      if (sweep_done) begin
        iss_idx_reg <= '0;
        wb_idx_reg  <= '0;
        iss_x_reg   <= '0;
        iss_y_reg   <= '0;
      end

      if (out_free) begin
        if (skid_valid_reg) begin
          out_valid      <= 1'b1;
          out_x          <= skid_x_reg;
          out_y          <= skid_y_reg;
          out_i          <= skid_i_reg;
          out_io         <= skid_io_reg;
          skid_valid_reg <= 1'b0;
        end else if (pend_reg) begin
          out_valid <= 1'b1;
          out_x     <= pend_x_reg;
          out_y     <= pend_y_reg;
          out_i     <= rd_data_i;
          out_io    <= rd_data_io;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (pend_reg) begin
        skid_valid_reg <= 1'b1;
        skid_x_reg     <= pend_x_reg;
        skid_y_reg     <= pend_y_reg;
        skid_i_reg     <= rd_data_i;
        skid_io_reg    <= rd_data_io;
      end
    end
  end

endmodule

// File: tb/tb_big_data_2d_sweep_ctrl.sv
// Directed bench for the 2-D sweep controller on a 3x2 array with memory and consumer models.
module tb_big_data_2d_sweep_ctrl;
  localparam int SX = 3, SY = 2, PER = 4, REP = 2, DW = 32;
  localparam int AW = 3, XW = 2, YW = 1;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready, wb_valid, init_req;
  logic [DW-1:0] wb_data, rd_data_i, rd_data_io;
  logic          rd_en, out_valid, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [DW-1:0] out_i, out_io, wr_data;
  logic [31:0]   pass_count;

  logic [DW-1:0] mem_i  [0:7];
  logic [DW-1:0] mem_io [0:7];

  int n_cmp = 0, n_bad = 0, cyc = 0, n_wb = 0;
  int resq[$];
  int accq[$];
  bit wb_hold = 1'b0;

  always #5 clk = ~clk;

  big_data_2d_sweep_ctrl #(
    .SIZE_X(SX), .SIZE_Y(SY), .PERIOD(PER), .REPEAT(REP), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_i(rd_data_i), .rd_data_io(rd_data_io),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_i(out_i), .out_io(out_io), .wb_valid(wb_valid), .wb_data(wb_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .pass_count(pass_count)
  );

  // Memory model with registered read.
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 8; k++) begin
        mem_i[k]  <= 32'(k);
        mem_io[k] <= 32'(100 + k);
      end
    end else begin
      if (rd_en) begin
        rd_data_i  <= mem_i[rd_addr];
        rd_data_io <= mem_io[rd_addr];
      end
      if (wr_en) mem_io[wr_addr] <= wr_data;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
    end else begin
      $display("  ok %s @cyc %0d: %0d", tag, cyc, act);
    end
  endtask

  // One clock: log the handshake about to happen, then drive the consumer's writeback.
  task automatic tick();
    if (out_valid && out_ready) begin
      resq.push_back(int'(out_i + out_io));
      accq.push_back(int'(out_x) * 16 + int'(out_y));
    end
    if (wb_valid) n_wb++;
    @(posedge clk);
    #1;
    cyc++;
    if (!wb_hold && resq.size() > 0) begin
      wb_valid = 1'b1;
      wb_data  = 32'(resq.pop_front());
    end else begin
      wb_valid = 1'b0;
      wb_data  = '0;
    end
    #1;
  endtask

  task automatic load_mem();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_pass(input int target);
    for (int i = 0; i < 200 && pass_count != 32'(target); i++) tick();
    check_val("pass_count", pass_count, target);
  endtask

  task automatic run_until_done();
    for (int i = 0; i < 300 && !done; i++) tick();
    check_val("done", done, 1);
    check_val("done_pass_count", pass_count, REP);
    check_val("done_busy", busy, 0);
  endtask

  task automatic check_order(input int n);
    check_val("order_count", accq.size(), n);
    for (int i = 0; i < accq.size(); i++)
      check_val("order_xy", accq[i], ((i % 6) / 2) * 16 + (i % 2));
    accq.delete();
  endtask

  task automatic check_mem(input int mult);
    for (int k = 0; k < 6; k++) check_val("mem_io", mem_io[k], 100 + mult * k);
  endtask

  task automatic check_reset();
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_rd_en", rd_en, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_pass_count", pass_count, 0);
    check_val("rst_rd_addr", rd_addr, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_out_x", out_x, 0);
    check_val("rst_out_y", out_y, 0);
    check_val("rst_out_i", out_i, 0);
    check_val("rst_out_io", out_io, 0);
    check_val("rst_wr_data", wr_data, 0);
  endtask

  initial begin
    int wait_cycles;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_data = '0; init_req = 1'b1;
    repeat (3) tick();
    init_req = 1'b0;
    check_reset();
    rst = 1'b0;
    tick();

    // Full run, consumer always ready, immediate writeback.
    pulse_start();
    wait_cycles = 0;
    for (int i = 0; i < 20 && !rd_en; i++) begin
      wait_cycles++;
      tick();
    end
    check_val("wait_cycles", wait_cycles, PER);
    for (int k = 0; k < 6; k++) begin
      check_val("rd_addr_seq", rd_en ? 64'(rd_addr) : 64'hFF, k);
      if (k == 0) check_val("out_valid_early", out_valid, 0);
      if (k == 2) check_val("out_valid_first", out_valid, 1);
      tick();
    end
    run_until_pass(1);
    check_order(6);
    check_mem(2);
    run_until_done();
    check_order(6);
    check_mem(3);

    // Consumer stalls three cycles on element 2; restart from DONE.
    load_mem();
    pulse_start();
    for (int i = 0; i < 100 && !(out_valid && out_x == 2'd1 && out_y == 1'b0); i++) tick();
    check_val("stall_reach", out_valid, 1);
    out_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      check_val("stall_rd_en", rd_en, 0);
      check_val("stall_x", out_x, 1);
      check_val("stall_y", out_y, 0);
      check_val("stall_i", out_i, 2);
      check_val("stall_io", out_io, 102);
      tick();
    end
    out_ready = 1'b1;
    run_until_pass(1);
    check_order(6);
    check_mem(2);
    run_until_done();
    check_order(6);
    check_mem(3);

    // Writebacks held back until 5 cycles after the last element.
    load_mem();
    wb_hold = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 && accq.size() < 6; i++) tick();
    check_val("drain_accepts", accq.size(), 6);
    for (int s = 0; s < 5; s++) begin
      check_val("drain_busy", busy, 1);
      check_val("drain_pass", pass_count, 0);
      tick();
    end
    wb_hold = 1'b0;
    n_wb = 0;
    for (int i = 0; i < 20 && n_wb < 5; i++) tick();
    check_val("pass_before_6th", pass_count, 0);
    for (int i = 0; i < 5 && pass_count == 0; i++) tick();
    check_val("pass_on_6th", pass_count, 1);
    check_val("wb_at_increment", n_wb, 6);
    check_order(6);
    run_until_done();
    check_order(6);
    check_mem(3);

    // Abort while element 3 of pass 1 is offered.
    load_mem();
    pulse_start();
    for (int i = 0; i < 100 && !(out_valid && out_x == 2'd1 && out_y == 1'b1); i++) tick();
    check_val("abort_reach", out_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    resq.delete();
    accq.delete();
    wb_valid = 1'b0;
    wb_data  = '0;
    #1;
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_pass_count", pass_count, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_rd_en", rd_en, 0);
    tick();
    check_val("abort_idle", busy, 0);
    load_mem();
    pulse_start();
    run_until_pass(1);
    check_order(6);
    check_mem(2);
    run_until_done();
    check_order(6);
    check_mem(3);

    // Reset together with start while in DRAIN.
    load_mem();
    wb_hold = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 && accq.size() < 6; i++) tick();
    tick();
    tick();
    check_val("pre_rst_busy", busy, 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
    start = 1'b0;
    resq.delete();
    accq.delete();
    wb_hold = 1'b0;
    tick();
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
